// File: rtl/led_data_tx_if.sv
// led_data_tx_if: host-to-transmitter word bus (wdata/wvalid/wready)
//   master: host side, drives wdata/wvalid, sees wready
//   slave : transmitter side, sees wdata/wvalid, drives wready
interface led_data_tx_if;
  logic [15:0] wdata;
  logic wvalid;
  logic wready;
  modport master(output wdata, output wvalid, input wready);
  modport slave(input wdata, input wvalid, output wready);
endinterface

// File: rtl/led_data_tx.sv
// led_data_tx: buffers 16-bit gray words in a small FIFO and shifts them out MSB first as DAI/DEN frames
//   DCK        data clock (rising edge)
//   rst        async active-low reset
//   clr        sync flush of FIFO, FSM and counters
//   host       word bus (wdata/wvalid in, wready out)
//   DAI/DEN    serial data and its valid strobe
//   busy       FSM in SHIFT or GAP
//   frame_done one-cycle pulse entering the inter-frame gap
//   word_cnt   index of the word being shifted
module led_data_tx #(
  parameter int FIFO_DEPTH = 4,
  parameter int FRAME_WORDS = 512,
  parameter int GAP = 2
) (
  input  logic DCK,
  input  logic rst,
  input  logic clr,
  led_data_tx_if.slave host,
  output logic DAI,
  output logic DEN,
  output logic busy,
  output logic frame_done,
  output logic [8:0] word_cnt
);
  localparam int AW = $clog2(FIFO_DEPTH);
  localparam int GW = GAP > 1 ? $clog2(GAP) : 1;
  typedef enum logic [1:0] {S_IDLE, S_SHIFT, S_GAP} state_t;
  logic [15:0] mem [FIFO_DEPTH];
  logic [AW-1:0] wp, rp;
  logic [AW:0] cnt;
  state_t state, n_state;
  logic [15:0] sreg, n_sreg;
  logic [3:0] bcnt, n_bcnt;
  logic [8:0] n_wcnt;
  logic [GW-1:0] gcnt, n_gcnt;
  logic n_den, n_done, load, push, avail, last;
  assign host.wready = cnt != (AW+1)'(FIFO_DEPTH);
  assign push = host.wvalid & host.wready;
  assign avail = cnt != '0;
  assign last = word_cnt == 9'(FRAME_WORDS - 1);
  assign busy = state != S_IDLE;
  // load doubles as the FIFO pop: every word leaves the FIFO exactly when it enters sreg
  always_comb begin
    n_state = state;
    n_sreg = sreg << 1;
    n_bcnt = bcnt - 4'd1;
    n_wcnt = word_cnt;
    n_gcnt = gcnt;
    n_den = 1'b0;
    n_done = 1'b0;
    load = 1'b0;
    case (state)
      S_IDLE: begin
        n_bcnt = 4'd0;
        load = avail;
      end
      S_SHIFT:
        if (bcnt != 4'd0) n_den = 1'b1;
        else if (last) begin
          n_state = S_GAP;
          n_bcnt = 4'd0;
          n_wcnt = '0;
          n_gcnt = GW'(GAP - 1);
          n_done = 1'b1;
        end else begin
          // underrun leaves word_cnt pointing at the word that will resume the frame
          n_state = S_IDLE;
          n_bcnt = 4'd0;
          n_wcnt = word_cnt + 9'd1;
          load = avail;
        end
      S_GAP: begin
        n_bcnt = 4'd0;
        n_gcnt = gcnt - GW'(1);
        // last gap cycle pops directly so the gap stays exactly GAP cycles long
        if (gcnt == '0) begin
          n_state = S_IDLE;
          load = avail;
        end
      end
      default: n_state = S_IDLE;
    endcase
    if (load) begin
      n_state = S_SHIFT;
      n_sreg = mem[rp];
      n_bcnt = 4'd15;
      n_den = 1'b1;
    end
  end
  always_ff @(posedge DCK or negedge rst)
    if (!rst) begin
      state <= S_IDLE;
      sreg <= '0;
      bcnt <= '0;
      gcnt <= '0;
      word_cnt <= '0;
      DAI <= 1'b0;
      DEN <= 1'b0;
      frame_done <= 1'b0;
      wp <= '0;
      rp <= '0;
      cnt <= '0;
    end else begin
      state <= clr ? S_IDLE : n_state;
      sreg <= clr ? '0 : n_sreg;
      bcnt <= clr ? '0 : n_bcnt;
      gcnt <= clr ? '0 : n_gcnt;
      word_cnt <= clr ? '0 : n_wcnt;
      DAI <= ~clr & n_den & n_sreg[15];
      DEN <= ~clr & n_den;
      frame_done <= ~clr & n_done;
      wp <= clr ? '0 : wp + AW'(push);
      rp <= clr ? '0 : rp + AW'(load);
      cnt <= clr ? '0 : cnt + (AW+1)'(push) - (AW+1)'(load);
    end
  always_ff @(posedge DCK)
    if (push && !clr) mem[wp] <= host.wdata;
endmodule

// File: doc/led_data_tx.md
LED_DATA_TX -- requirements
Module: led_data_tx

Interface
REQ-001 Parameter FIFO_DEPTH, default 4: word FIFO depth; power of two, at least 2.
REQ-002 Parameter FRAME_WORDS, default 512: words per frame; matches 512x16 frame store.
REQ-003 Parameter GAP, default 2: DEN-low cycles inserted after each frame; at least 1.
REQ-004 DCK  input  1  data clock; all state on rising edge; only clock.
REQ-005 rst  input  1  reset; asynchronous assert, active-low (0 = reset); synchronous deassert handled upstream.
REQ-006 clr  input  1  synchronous flush; abort frame, empty FIFO, zero counters.
REQ-007 wdata  input  16  gray word from host.
REQ-008 wvalid  input  1  wdata valid.
REQ-009 wready  output  1  FIFO can accept; transfer = wvalid & wready at rising DCK.
REQ-010 DAI  output  1  serial data to display controller, MSB first.
REQ-011 DEN  output  1  high while DAI carries a valid bit.
REQ-012 busy  output  1  high in SHIFT or GAP.
REQ-013 frame_done  output  1  one-cycle pulse at frame end.
REQ-014 word_cnt  output  9  index of word currently shifting; 0..FRAME_WORDS-1.

Function
REQ-015 All outputs registered; no combinational path input->output except none (wready from registered FIFO count).
REQ-016 FIFO: FIFO_DEPTH x 16, wrapping read/write pointers, count 0..FIFO_DEPTH; wready = (count != FIFO_DEPTH).
REQ-017 Push and pop on same edge: count unchanged, both pointers advance; push ignored when full (wready=0).
REQ-018 FSM states IDLE, SHIFT, GAP; 4-bit bit counter bcnt, 16-bit shift register sreg.
REQ-019 IDLE: if count>0, pop at edge -> SHIFT, sreg=word, bcnt=15; DAI=word[15], DEN=1 from that edge.
REQ-020 Latency: word pushed into empty FIFO at edge k appears as DAI bit15 with DEN=1 after edge k+1.
REQ-021 SHIFT: each edge shifts sreg left, bcnt decrements; DAI=sreg[15]; 16 DEN-high cycles per word.
REQ-022 At bcnt=0, not last frame word, count>0: pop same edge, next bit15 follows immediately, DEN stays 1, word_cnt+1.
REQ-023 At bcnt=0, not last frame word, count=0: -> IDLE, DEN=0, DAI=0, word_cnt held; resume at REQ-019 (underrun stall, frame not aborted).
REQ-024 At bcnt=0 and word_cnt=FRAME_WORDS-1: -> GAP, DEN=0, word_cnt wraps to 0, frame_done=1 for first GAP cycle only.
REQ-025 GAP: DEN=0 for exactly GAP cycles, no pop; then -> IDLE (which pops if count>0).
REQ-026 DAI=0 whenever DEN=0.
REQ-027 clr=1: at that edge FIFO emptied, FSM->IDLE, bcnt=0, word_cnt=0, DEN=0, DAI=0, frame_done=0; concurrent push discarded; clr overrides all.
REQ-028 busy = (state != IDLE).

Reset
REQ-029 rst=0 asynchronously forces: FIFO count/pointers 0, state IDLE, sreg 0, bcnt 0, word_cnt 0, DAI 0, DEN 0, frame_done 0, busy 0, wready 1.
REQ-030 Reset mid-word or mid-frame discards partial word and frame; first word after reset is word_cnt 0.

Verification
REQ-031 Single word 16'hA5C3 into idle block -> DEN high 16 cycles starting edge k+1, DAI = 1010010111000011, then DEN 0, word_cnt 1.
REQ-032 512 back-to-back words, wvalid held -> DEN continuous 8192 cycles, frame_done exactly once, 2 DEN-low cycles, word_cnt 0.
REQ-033 wvalid held, consumer-side stall-free, 5 pushes at once -> wready drops after 4th, count 4, no word lost/duplicated.
REQ-034 Gap host after word 3 of frame -> DEN low while count=0, resume with word 4 bit15, word_cnt=4, frame not ended.
REQ-035 clr at word 100 bit 7 with FIFO count 3 -> next cycle DEN 0, count 0, word_cnt 0, wready 1; next push starts word 0.
REQ-036 rst low mid-word -> all outputs at REQ-029 values immediately, without waiting for DCK edge.
